instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction producer that feeds `control_unit` and the decode stage of the RV32I core. It holds the PC and issues word-aligned fetch requests to instruction memory over a valid/ready channel. Returned words are placed in a one-entry output buffer, which is presented to decode with a valid/ready handshake. Branch/jump redirects from execute are applied with the stale-response squashing described below.

Parameters:
RESET_PC, 32'h0100_0000, PC value loaded on reset; must be 4-byte aligned.
XLEN, 32, address and instruction width.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  XLEN  fetch byte address; always 4-aligned
imem_req_ready  input  1  memory accepts the request this cycle
imem_resp_valid  input  1  response word valid; one response per accepted request, at least 1 cycle after acceptance
imem_resp_data  input  32  fetched instruction word
instr_valid  output  1  output buffer holds an instruction for decode
instruction  output  32  instruction to `control_unit`
instr_pc  output  XLEN  PC of `instruction`
instr_ready  input  1  decode consumes `instruction` this cycle
redirect_valid  input  1  taken branch/jump; single-cycle pulse
redirect_pc  input  XLEN  redirect target
fetch_fault  output  1  sticky misaligned-redirect flag

Behaviour:
- Reset (async assert, sync release), all outputs registered:
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC
  - fetch_fault=0, pc=RESET_PC, drop=0, state=IDLE
- Reset mid-operation discards any in-flight request. The memory is reset with the same rst.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready, next state is WAIT. Otherwise, address and valid are held unchanged (redirect is the only exception).
  - WAIT: imem_req_valid=0. On imem_resp_valid:
    - drop=1: clear drop, go to REQ.
    - drop=0: load instruction<=data and instr_pc<=pc, set pc<=pc+4, set instr_valid=1, go to HOLD.
  - HOLD: instr_valid=1; buffer contents stable. On instr_ready: instr_valid<=0, go to REQ.
  - FAULT: terminal until reset. No requests, instr_valid=0, fetch_fault=1. An outstanding response is absorbed and ignored.
- Timing:
  - Zero-wait memory (ready=1, response 1 cycle after acceptance): REQ→WAIT→HOLD. instr_valid rises 2 cycles after the REQ cycle.
  - Steady-state throughput with instr_ready=1: one instruction per 3 cycles.
- Redirect (redirect_valid=1) has priority over every other event:
  - pc<=redirect_pc; instr_valid<=0 next cycle.
  - REQ, not accepted: stay in REQ with the new address next cycle.
  - REQ, accepted same cycle: WAIT with drop=1.
  - WAIT, no response this cycle: stay in WAIT, drop=1.
  - WAIT, response this cycle: the response is discarded, go to REQ.
  - HOLD (with or without instr_ready): buffer squashed, go to REQ.
  - IDLE: go to REQ with the new pc.
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_fault<=1, go to FAULT.
  - If a request is outstanding or accepted that cycle, drop=1 and the response is absorbed in FAULT.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC increments to 32'h0000_0000.
  - imem_req_addr[1:0] is always 2'b00.
- Never more than one outstanding request.
- imem_resp_valid in IDLE, REQ or HOLD is a protocol violation. It is ignored and flagged by a simulation-only assertion.

Decomposition:
- Add to shared package rv32i_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, FAULT}
  - NOP_INSTR = 32'h0000_0013
  - INSTR_BYTES = 4
  - DEFAULT_RESET_PC
- No sub-module; the single FSM and PC register live in one module.

Test Plan:
- Reset release with ready=1 and 1-cycle memory returning 32'h0010_0093: first request address is 32'h0100_0000, then 32'h0100_0004. instr_valid rises 2 cycles after the first REQ with instruction=32'h0010_0093 and instr_pc=32'h0100_0000.
- imem_req_ready held low 3 cycles: imem_req_valid and addr 32'h0100_0004 stay stable; accepted on the 4th cycle.
- instr_ready low 5 cycles in HOLD: instruction and instr_pc unchanged and no new request. Raise instr_ready: the next request follows the cycle after.
- redirect_pc=32'h0100_0040 pulsed in WAIT, stale response 32'hDEAD_BEEF arrives next cycle: 32'hDEAD_BEEF is never presented. Next request address is 32'h0100_0040.
- redirect_pc=32'hFFFF_FFFC, then a second fetch: second request address is 32'h0000_0000.
- redirect_pc=32'h0100_0042: fetch_fault=1 sticky, no further imem_req_valid. rst clears it and fetch restarts at 32'h0100_0000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions used by the fetch front end.
package rv32i_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding imem requests and a
// one-entry decode buffer, with redirect squashing of stale responses.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            w_valid_nxt;
  logic [31:0]     w_instr_nxt;
  logic [XLEN-1:0] w_ipc_nxt;
  logic            w_misaligned;
  logic            w_outstanding;

  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
  // A response is still owed after this edge: accepted now, or waited on and not arriving now.
  assign w_outstanding = ((r_state == REQ) && imem_req_ready) ||
                         ((r_state == WAIT) && !imem_resp_valid);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_valid_nxt = instr_valid;
    w_instr_nxt = instruction;
    w_ipc_nxt   = instr_pc;

    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = REQ;
          end else begin
            w_instr_nxt = imem_resp_data;
            w_ipc_nxt   = r_pc;
            w_pc_nxt    = r_pc + XLEN'(INSTR_BYTES);
            w_valid_nxt = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = REQ;
        end
      end
      FAULT: begin
        if (imem_resp_valid) w_drop_nxt = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Redirect overrides everything; FAULT is terminal until reset.
    if (redirect_valid && (r_state != FAULT)) begin
      w_valid_nxt = 1'b0;
      w_drop_nxt  = w_outstanding;
      if (w_misaligned) begin
        w_state_nxt = FAULT;
      end else begin
        w_pc_nxt    = redirect_pc;
        w_state_nxt = w_outstanding ? WAIT : REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_drop         <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      instr_valid    <= 1'b0;
      instruction    <= NOP_INSTR;
      instr_pc       <= RESET_PC;
      fetch_fault    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_drop         <= w_drop_nxt;
      imem_req_valid <= (w_state_nxt == REQ);
      imem_req_addr  <= w_pc_nxt;
      instr_valid    <= w_valid_nxt;
      instruction    <= w_instr_nxt;
      instr_pc       <= w_ipc_nxt;
      fetch_fault    <= (w_state_nxt == FAULT);
    end
  end

  // Responses are only legal while one is owed.
  a_resp_protocol: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((r_state == WAIT) || (r_state == FAULT)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timeline scenarios plus a randomized
// run checked against an in-order PC-stream reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model state and settings (settings written by the test, read by the memory).
  logic [31:0] mem [logic [31:0]];
  int          mem_block = 0;
  int          mem_lat   = 0;
  bit          mem_rand  = 0;
  bit          m_pend;
  int          m_lat;
  int          m_stall;
  logic [31:0] m_addr;
  bit          saw_beef = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: one response per accepted request, with configurable latency.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    m_pend = 0; m_lat = 0; m_stall = 0; m_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 0; m_stall = 0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
      end else begin
        if (imem_resp_valid) begin
          imem_resp_valid = 1'b0;
          m_pend = 0;
        end else if (m_pend) begin
          if (m_lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(m_addr);
          end else begin
            m_lat--;
          end
        end
        imem_req_ready = 1'b0;
        if (!m_pend && imem_req_valid) begin
          if (m_stall < mem_block) begin
            m_stall++;
          end else if (mem_rand && $urandom_range(0, 1) == 0) begin
            m_stall = 0;
          end else begin
            imem_req_ready = 1'b1;
            m_pend = 1; m_stall = 0;
            m_addr = imem_req_addr;
            m_lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid && instruction == 32'hDEAD_BEEF) saw_beef = 1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #1 rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({imem_req_valid, instr_valid, fetch_fault} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {imem_req_valid, instr_valid, fetch_fault}); else n_pass++;
    n_checks++; if (imem_req_addr !== RST_PC) $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RST_PC); else n_pass++;
    n_checks++; if (instruction !== NOP) $display("FAIL reset_instr: got %h expected %h", instruction, NOP); else n_pass++;
    n_checks++; if (instr_pc !== RST_PC) $display("FAIL reset_ipc: got %h expected %h", instr_pc, RST_PC); else n_pass++;
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL pre_async_valid: got %b expected 1", instr_valid); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({imem_req_valid, instr_valid} !== 2'b00) $display("FAIL async_reset_valid: got %b expected 00", {imem_req_valid, instr_valid}); else n_pass++;
    n_checks++; if ({instruction, instr_pc} !== {NOP, RST_PC}) $display("FAIL async_reset_buf: got %h expected %h", {instruction, instr_pc}, {NOP, RST_PC}); else n_pass++;
  endtask

  task automatic test_first_fetch();
    apply_reset();
    @(negedge clk);
    n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) $display("FAIL first_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC); else n_pass++;
    @(negedge clk);
    n_checks++; if ({imem_req_valid, instr_valid} !== 2'b00) $display("FAIL first_wait: got %b expected 00", {imem_req_valid, instr_valid}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'h0010_0093, RST_PC})
      $display("FAIL first_instr: got %b/%h/%h expected 1/00100093/%h", instr_valid, instruction, instr_pc, RST_PC); else n_pass++;
  endtask

  task automatic test_hold_stall();
    mem_block = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({instr_valid, imem_req_valid, instruction, instr_pc} !== {2'b10, 32'h0010_0093, RST_PC})
        $display("FAIL hold_stable_%0d: got %b%b/%h/%h expected 10/00100093/%h", i, instr_valid, imem_req_valid, instruction, instr_pc, RST_PC); else n_pass++;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if ({imem_req_valid, instr_valid, imem_req_addr} !== {2'b10, RST_PC + 32'd4})
      $display("FAIL hold_release_req: got %b%b/%h expected 10/%h", imem_req_valid, instr_valid, imem_req_addr, RST_PC + 32'd4); else n_pass++;
  endtask

  task automatic test_req_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC + 32'd4})
        $display("FAIL req_stall_%0d: got %b/%h expected 1/%h", i, imem_req_valid, imem_req_addr, RST_PC + 32'd4); else n_pass++;
    end
    @(negedge clk);
    mem_block = 0;
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL req_accept: got %b expected 0", imem_req_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'h0020_8113, RST_PC + 32'd4})
      $display("FAIL second_instr: got %b/%h/%h expected 1/00208113/%h", instr_valid, instruction, instr_pc, RST_PC + 32'd4); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    mem_lat = 1; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC + 32'd8})
      $display("FAIL third_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC + 32'd8); else n_pass++;
    @(negedge clk);
    mem_lat = 0;
    n_checks++; if ({imem_req_valid, instr_valid} !== 2'b00) $display("FAIL wait_state: got %b expected 00", {imem_req_valid, instr_valid}); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if ({imem_req_valid, instr_valid} !== 2'b00) $display("FAIL redirect_still_wait: got %b expected 00", {imem_req_valid, instr_valid}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({imem_req_valid, instr_valid, imem_req_addr} !== {2'b10, 32'h0100_0040})
      $display("FAIL redirect_req: got %b%b/%h expected 10/01000040", imem_req_valid, instr_valid, imem_req_addr); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'h0031_0193, 32'h0100_0040})
      $display("FAIL redirect_instr: got %b/%h/%h expected 1/00310193/01000040", instr_valid, instruction, instr_pc); else n_pass++;
    n_checks++; if (saw_beef !== 1'b0) $display("FAIL stale_presented: got %b expected 0", saw_beef); else n_pass++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if ({imem_req_valid, instr_valid, imem_req_addr} !== {2'b10, 32'hFFFF_FFFC})
      $display("FAIL wrap_req: got %b%b/%h expected 10/fffffffc", imem_req_valid, instr_valid, imem_req_addr); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if ({instr_valid, instruction, instr_pc} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC})
      $display("FAIL wrap_instr: got %b/%h/%h expected 1/%h/fffffffc", instr_valid, instruction, instr_pc, mem_word(32'hFFFF_FFFC)); else n_pass++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0000})
      $display("FAIL wrap_next_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if ({instr_valid, instruction, instr_pc} !== {1'b1, mem_word(32'h0), 32'h0})
      $display("FAIL wrap_next_instr: got %b/%h/%h expected 1/%h/00000000", instr_valid, instruction, instr_pc, mem_word(32'h0)); else n_pass++;
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      redirect_valid = (i == 3); redirect_pc = 32'h0100_0100;
      n_checks++; if ({fetch_fault, imem_req_valid, instr_valid} !== 3'b100)
        $display("FAIL fault_sticky_%0d: got %b expected 100", i, {fetch_fault, imem_req_valid, instr_valid}); else n_pass++;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (fetch_fault !== 1'b0) $display("FAIL fault_reset: got %b expected 0", fetch_fault); else n_pass++;
    repeat (2) @(negedge clk);
    mem_lat = 2;
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC})
      $display("FAIL restart_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC); else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0; mem_lat = 0;
      n_checks++; if ({fetch_fault, imem_req_valid, instr_valid} !== 3'b100)
        $display("FAIL fault_inflight_%0d: got %b expected 100", i, {fetch_fault, imem_req_valid, instr_valid}); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int          n_cons;
    bit          redir;
    mem_rand = 1;
    apply_reset();
    exp_pc = RST_PC;
    n_cons = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        n_checks++; if (imem_req_addr[1:0] !== 2'b00) $display("FAIL rand_align: got %h expected 4-aligned", imem_req_addr); else n_pass++;
      end
      if (instr_valid) begin
        n_checks++; if ({instr_pc, instruction} !== {exp_pc, mem_word(exp_pc)})
          $display("FAIL rand_stream cyc %0d: got %h/%h expected %h/%h", c, instr_pc, instruction, exp_pc, mem_word(exp_pc)); else n_pass++;
      end
      redir = !redirect_valid && ($urandom_range(0, 15) == 0);
      redirect_valid = redir;
      if (redir)
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4
                                                  : 32'h0200_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      instr_ready = ($urandom_range(0, 2) != 0);
      if (redir) exp_pc = redirect_pc;
      else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
    end
    redirect_valid = 1'b0;
    n_checks++; if (n_cons < 100) $display("FAIL rand_progress: got %0d consumed expected at least 100", n_cons); else n_pass++;
  endtask

  initial begin
    mem[RST_PC]            = 32'h0010_0093;
    mem[RST_PC + 32'd4]    = 32'h0020_8113;
    mem[RST_PC + 32'd8]    = 32'hDEAD_BEEF;
    mem[32'h0100_0040]     = 32'h0031_0193;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_req_stall();
    test_redirect_wait();
    test_wrap();
    test_fault();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
